// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline register and its skid stages.
package pipe_pkg;

    localparam int unsigned MAX_DEPTH = 8;

    // Width needed to count 0..2*depth held entries.
    function automatic int unsigned OCC_W(input int unsigned depth);
        return $clog2(2 * depth + 1);
    endfunction

endpackage

// File: rtl/elastic_pipe_reg_skid_stage.sv
// One elastic stage: a main register backed by a skid register so that
// the upstream ready only depends on local state (registered ready).
module skid_stage
    import pipe_pkg::*;
#(
    parameter int unsigned          WIDTH     = 32,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic [1:0]       count_o
);

    logic             mv_q, mv_d;
    logic             sv_q, sv_d;
    logic [WIDTH-1:0] md_q, md_d;
    logic [WIDTH-1:0] sd_q, sd_d;
    logic             pop;
    logic             push;

    assign pop  = mv_q & out_ready_i;
    assign push = in_valid_i & ~sv_q;

    always_comb begin
        mv_d = mv_q;
        sv_d = sv_q;
        md_d = md_q;
        sd_d = sd_q;
        if (pop && sv_q) begin
            // skid set implies no push this edge, so only the refill happens
            md_d = sd_q;
            sv_d = 1'b0;
        end else if (pop) begin
            mv_d = push;
            if (push) md_d = in_data_i;
        end else if (push) begin
            if (!mv_q) begin
                mv_d = 1'b1;
                md_d = in_data_i;
            end else begin
                sv_d = 1'b1;
                sd_d = in_data_i;
            end
        end
        if (flush) begin
            mv_d = 1'b0;
            sv_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mv_q <= 1'b0;
            sv_q <= 1'b0;
            md_q <= RESET_VAL;
            sd_q <= RESET_VAL;
        end else begin
            mv_q <= mv_d;
            sv_q <= sv_d;
            md_q <= md_d;
            sd_q <= sd_d;
        end
    end

    assign in_ready_o  = ~sv_q;
    assign out_valid_o = mv_q;
    assign out_data_o  = md_q;
    assign count_o     = {1'b0, mv_q} + {1'b0, sv_q};

endmodule

// File: rtl/elastic_pipe_reg.sv
// DEPTH-stage elastic pipeline register: chained skid stages with
// valid/ready handshake, synchronous flush and an occupancy count.
module elastic_pipe_reg
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH     = 32,
    parameter int unsigned      DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [OCC_W(DEPTH)-1:0]    occupancy
);

    localparam int unsigned OW = OCC_W(DEPTH);

    if (DEPTH < 1 || DEPTH > MAX_DEPTH || WIDTH < 1 || WIDTH > 64) begin : g_bad_param
        $error("elastic_pipe_reg: illegal WIDTH=%0d / DEPTH=%0d", WIDTH, DEPTH);
    end

    logic [DEPTH:0]              vld;
    logic [DEPTH:0]              rdy;
    logic [DEPTH:0][WIDTH-1:0]   dat;
    logic [DEPTH-1:0][1:0]       cnt;
    logic [OW-1:0]               occ_sum;

    assign vld[0]     = in_valid;
    assign dat[0]     = in_data;
    assign in_ready   = rdy[0];
    assign out_valid  = vld[DEPTH];
    assign out_data   = dat[DEPTH];
    assign rdy[DEPTH] = out_ready;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        skid_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk         (clk),
            .rst         (rst),
            .flush       (flush),
            .in_valid_i  (vld[k]),
            .in_ready_o  (rdy[k]),
            .in_data_i   (dat[k]),
            .out_valid_o (vld[k+1]),
            .out_ready_i (rdy[k+1]),
            .out_data_o  (dat[k+1]),
            .count_o     (cnt[k])
        );
    end

    // Sum of registered valid bits, so it moves on the same edge as the entries.
    always_comb begin
        occ_sum = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            occ_sum = occ_sum + OW'(cnt[k]);
        end
    end

    assign occupancy = occ_sum;

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Bench for elastic_pipe_reg: table-driven streaming plus hand sequences and
// a randomized queue-scoreboard run, across DEPTH=2/3/4 instances.
module tb_elastic_pipe_reg;
    import pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_data;

    logic r2, v2, r3, v3, r4, v4;
    logic [31:0] d2, d3, d4;
    logic [OCC_W(2)-1:0] o2;
    logic [OCC_W(3)-1:0] o3;
    logic [OCC_W(4)-1:0] o4;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    elastic_pipe_reg #(.WIDTH(32), .DEPTH(2), .RESET_VAL(32'hDEADBEEF)) u_d2 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(r2),
        .in_data(in_data), .out_valid(v2), .out_ready(out_ready), .out_data(d2),
        .occupancy(o2));
    elastic_pipe_reg #(.WIDTH(32), .DEPTH(3)) u_d3 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(r3),
        .in_data(in_data), .out_valid(v3), .out_ready(out_ready), .out_data(d3),
        .occupancy(o3));
    elastic_pipe_reg #(.WIDTH(32), .DEPTH(4)) u_d4 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(r4),
        .in_data(in_data), .out_valid(v4), .out_ready(out_ready), .out_data(d4),
        .occupancy(o4));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        step();
        rst = 1'b0;
    endtask

    // Push n values base, base+1, ... into the DEPTH=2 pipe with out_ready low.
    task automatic fill_u2(input int n, input int base);
        int acc = 0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int c = 0; c < 20 && acc < n; c++) begin
            logic take;
            in_data = 32'(base + acc);
            take = r2;
            step();
            if (take) acc++;
        end
        in_valid = 1'b0;
        chk("fill_u2_count", 64'(acc), 64'(n));
    endtask

    typedef struct {
        logic        iv;
        logic [31:0] id;
        logic        ordy;
        logic        ev;
        logic [31:0] ed;
        logic [2:0]  eocc;
    } vec_t;

    vec_t tbl[13];

    initial begin
        // ---------------- reset ----------------
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1; in_data = 32'h1234_5678;
        step();
        step();
        chk("rst_out_valid", 64'(v2), 64'd0);
        chk("rst_in_ready",  64'(r2), 64'd1);
        chk("rst_occupancy", 64'(o2), 64'd0);
        chk("rst_out_data",  64'(d2), 64'hDEADBEEF);
        rst = 1'b0; in_valid = 1'b0;
        step();

        // ---------------- streaming, DEPTH=3 (table) ----------------
        // Entry i: inputs before edge i, expected outputs after edge i.
        for (int i = 0; i < 13; i++) begin
            int pushed, popped;
            pushed = (i + 1 < 10) ? i + 1 : 10;
            popped = ((i < 12 ? i : 12) - 2 > 0) ? (i < 12 ? i : 12) - 2 : 0;
            tbl[i].iv   = (i < 10);
            tbl[i].id   = 32'(i + 1);
            tbl[i].ordy = 1'b1;
            tbl[i].ev   = (i >= 2 && i <= 11);
            tbl[i].ed   = 32'(i - 1);
            tbl[i].eocc = 3'(pushed - popped);
        end
        do_reset();
        for (int i = 0; i < 13; i++) begin
            in_valid  = tbl[i].iv;
            in_data   = tbl[i].id;
            out_ready = tbl[i].ordy;
            step();
            chk("stream_out_valid", 64'(v3), 64'(tbl[i].ev));
            chk("stream_in_ready",  64'(r3), 64'd1);
            chk("stream_occupancy", 64'(o3), 64'(tbl[i].eocc));
            if (tbl[i].ev) chk("stream_out_data", 64'(d3), 64'(tbl[i].ed));
        end
        in_valid = 1'b0;

        // ---------------- fill and stall, DEPTH=2 ----------------
        begin
            logic [31:0] vals[5];
            int idx = 0, nout = 0;
            for (int i = 0; i < 5; i++) vals[i] = 32'(5 + i);
            do_reset();
            out_ready = 1'b0;
            in_valid  = 1'b1;
            for (int c = 0; c < 8; c++) begin
                logic take;
                in_data = vals[idx];
                take = r2;
                step();
                if (take) begin
                    idx++;
                    if (idx == 4) chk("full_in_ready_after_4th", 64'(r2), 64'd0);
                end
            end
            chk("full_accepted", 64'(idx), 64'd4);
            chk("full_in_ready", 64'(r2), 64'd0);
            chk("full_occupancy", 64'(o2), 64'd4);
            chk("full_head_data", 64'(d2), 64'd5);
            out_ready = 1'b1;
            for (int c = 0; c < 20 && nout < 5; c++) begin
                logic take;
                if (v2) begin
                    chk("drain_data", 64'(d2), 64'(vals[nout]));
                    nout++;
                end
                in_data = vals[idx < 5 ? idx : 4];
                take = in_valid && r2;
                step();
                if (take) idx++;
                if (idx == 5) in_valid = 1'b0;
            end
            chk("drain_count", 64'(nout), 64'd5);
            chk("drain_occupancy", 64'(o2), 64'd0);
        end

        // ---------------- flush, DEPTH=2 ----------------
        begin
            int seen = 0;
            do_reset();
            fill_u2(3, 10);
            chk("flush_pre_occupancy", 64'(o2), 64'd3);
            flush = 1'b1; in_valid = 1'b1; in_data = 32'd13;
            step();
            flush = 1'b0; in_valid = 1'b0;
            chk("flush_occupancy", 64'(o2), 64'd0);
            chk("flush_out_valid", 64'(v2), 64'd0);
            chk("flush_in_ready",  64'(r2), 64'd1);
            out_ready = 1'b1;
            for (int c = 0; c < 4; c++) begin
                step();
                chk("flush_no_13", 64'(v2), 64'd0);
            end
            in_valid = 1'b1; in_data = 32'd14;
            step();
            in_valid = 1'b0;
            for (int c = 0; c < 10; c++) begin
                if (v2) begin
                    chk("flush_then_14", 64'(d2), 64'd14);
                    seen++;
                end
                step();
            end
            chk("flush_14_count", 64'(seen), 64'd1);
        end

        // ---------------- reset mid-stream, rst beats flush ----------------
        do_reset();
        fill_u2(3, 20);
        chk("midrst_pre_occupancy", 64'(o2), 64'd3);
        out_ready = 1'b1; rst = 1'b1; flush = 1'b1;
        step();
        rst = 1'b0; flush = 1'b0;
        chk("midrst_out_valid", 64'(v2), 64'd0);
        chk("midrst_occupancy", 64'(o2), 64'd0);
        chk("midrst_out_data",  64'(d2), 64'hDEADBEEF);
        chk("midrst_in_ready",  64'(r2), 64'd1);

        // ---------------- random backpressure, DEPTH=4 ----------------
        begin
            logic [31:0] q[$];
            int outs = 0, cyc = 0;
            logic hold_out = 1'b0;
            logic [31:0] hold_d = '0;
            do_reset();
            while (outs < 1000 && cyc < 20000) begin
                int bias;
                logic push, pop;
                chk("rnd_occupancy", 64'(o4), 64'(q.size()));
                if (q.size() == 0) begin
                    chk("rnd_empty_valid", 64'(v4), 64'd0);
                    chk("rnd_empty_ready", 64'(r4), 64'd1);
                end else if (v4) begin
                    chk("rnd_out_data", 64'(d4), 64'(q[0]));
                end
                if (hold_out) begin
                    chk("rnd_stable_valid", 64'(v4), 64'd1);
                    chk("rnd_stable_data",  64'(d4), 64'(hold_d));
                end
                // Upstream keeps an unaccepted offer unchanged.
                if (!(in_valid && !r4)) begin
                    in_valid = ($urandom_range(0, 3) != 0);
                    in_data  = $urandom;
                end
                bias = ((outs / 250) % 2 == 1) ? 30 : 85;
                out_ready = ($urandom_range(0, 99) < bias);
                push = in_valid && r4;
                pop  = v4 && out_ready && (q.size() != 0);
                hold_out = v4 && !out_ready;
                hold_d   = d4;
                if (pop) begin
                    void'(q.pop_front());
                    outs++;
                end
                if (push) q.push_back(in_data);
                step();
                cyc++;
            end
            chk("rnd_transfers_done", 64'(outs), 64'd1000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
